// File: rtl/blob_frame_feeder.sv
`default_nettype none
// ============================================================================
// Module   : blob_frame_feeder
// Purpose  : Captures one grayscale camera frame (pixel-valid gaps allowed),
//            binarizes it against a per-frame threshold into a 1-bit frame
//            store, then replays the frame as a gap-free bit stream preceded
//            by a one-cycle start pulse.  The next frame is held off until
//            the downstream blob counter reports done.
//
// Ports    : i_clk          sole clock, rising edge
//            i_rst_n        asynchronous active-low reset
//            i_frame_start  first pixel of a frame (i_pix_valid also high)
//            i_pix_valid    i_gray carries a pixel this cycle
//            i_gray[7:0]    luminance, row-major
//            i_threshold    binarization threshold, taken at frame start
//            i_blob_done    downstream counter finished the frame
//            o_valid        one-cycle start pulse ahead of the stream
//            o_seq          binary pixel stream
//            o_busy         high in every state except WAIT
//            o_drop_cnt     saturating count of dropped/aborted frames
//
// Options  : BLOB_FEEDER_ERODE_EN - when defined, each replayed bit is the
//            AND of the pixel and its left/right neighbours in the same row.
//
// Revision : 1.0 - initial release
// ============================================================================
module blob_frame_feeder #(
    parameter int IMG_COL = 640,
    parameter int IMG_ROW = 480
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_frame_start,
    input  logic       i_pix_valid,
    input  logic [7:0] i_gray,
    input  logic [7:0] i_threshold,
    input  logic       i_blob_done,
    output logic       o_valid,
    output logic       o_seq,
    output logic       o_busy,
    output logic [7:0] o_drop_cnt
);

    localparam int c_TOTAL  = IMG_COL * IMG_ROW;
    localparam int c_ADDR_W = (c_TOTAL > 1) ? $clog2(c_TOTAL) : 1;
    localparam int c_COL_W  = (IMG_COL > 1) ? $clog2(IMG_COL) : 1;
    localparam int c_ROW_W  = (IMG_ROW > 1) ? $clog2(IMG_ROW) : 1;

    localparam logic [c_ADDR_W-1:0] c_ADDR_ZERO = c_ADDR_W'(0);
    localparam logic [c_ADDR_W-1:0] c_ADDR_ONE  = c_ADDR_W'(1);
    localparam logic [c_ADDR_W-1:0] c_LAST_ADDR = c_ADDR_W'(c_TOTAL - 1);
    localparam logic [c_COL_W-1:0]  c_COL_ZERO  = c_COL_W'(0);
    localparam logic [c_COL_W-1:0]  c_COL_ONE   = c_COL_W'(1);
    localparam logic [c_COL_W-1:0]  c_LAST_COL  = c_COL_W'(IMG_COL - 1);
    localparam logic [c_ROW_W-1:0]  c_ROW_ZERO  = c_ROW_W'(0);
    localparam logic [c_ROW_W-1:0]  c_ROW_ONE   = c_ROW_W'(1);
    localparam logic [c_ROW_W-1:0]  c_LAST_ROW  = c_ROW_W'(IMG_ROW - 1);
    localparam logic [7:0]          c_DROP_MAX  = 8'hFF;

    localparam logic [2:0] c_S_WAIT     = 3'd0;
    localparam logic [2:0] c_S_CAPTURE  = 3'd1;
    localparam logic [2:0] c_S_PREFETCH = 3'd2;
    localparam logic [2:0] c_S_ARM      = 3'd3;
    localparam logic [2:0] c_S_REPLAY   = 3'd4;
    localparam logic [2:0] c_S_HOLD     = 3'd5;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [2:0]          r_state;
    logic [c_ADDR_W-1:0] r_waddr;
    logic [c_ADDR_W-1:0] r_raddr;
    logic [7:0]          r_thr;
    logic [c_COL_W-1:0]  r_col;
    logic [c_ROW_W-1:0]  r_row;
    logic                r_pf_cnt;
    logic                r_last;
    logic                r_valid;
    logic                r_seq;
    logic [7:0]          r_drop_cnt;

    logic                r_mem [0:c_TOTAL-1];
    logic                r_rdata;
    logic                r_sh1;
`ifdef BLOB_FEEDER_ERODE_EN
    logic                r_sh2;
`endif

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic                w_we;
    logic [c_ADDR_W-1:0] w_waddr;
    logic                w_wbit;
    logic                w_drop;
    logic                w_emit;
    logic                w_rd_adv;
    logic                w_border;
    logic                w_core;
    logic                w_rep_bit;

    // Store write port.  A frame start compares against the live threshold
    // input because r_thr only picks it up at the end of that cycle.  The
    // final pixel of a frame wins over a coincident frame start.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_waddr;
        w_wbit  = (i_gray >= r_thr);
        case (r_state)
            c_S_WAIT: begin
                if (i_frame_start) begin
                    w_we    = 1'b1;
                    w_waddr = c_ADDR_ZERO;
                    w_wbit  = (i_gray >= i_threshold);
                end
            end
            c_S_CAPTURE: begin
                if (i_pix_valid && (r_waddr == c_LAST_ADDR)) begin
                    w_we = 1'b1;
                end else if (i_frame_start) begin
                    w_we    = 1'b1;
                    w_waddr = c_ADDR_ZERO;
                    w_wbit  = (i_gray >= i_threshold);
                end else if (i_pix_valid) begin
                    w_we = 1'b1;
                end
            end
            default: begin
                w_we = 1'b0;
            end
        endcase
    end

    // Any frame start outside WAIT is lost: an abort while capturing, a
    // collision with the final capture write, or a frame arriving while the
    // stored one is still being replayed or consumed.
    assign w_drop   = i_frame_start && (r_state != c_S_WAIT);

    // One output bit is computed per cycle in ARM and in REPLAY up to the
    // last pixel; the read address runs one pixel ahead of the output.
    assign w_emit   = (r_state == c_S_ARM) || ((r_state == c_S_REPLAY) && !r_last);
    assign w_rd_adv = (r_state == c_S_PREFETCH) || (r_state == c_S_ARM) ||
                      (r_state == c_S_REPLAY);

    // Read pipeline alignment while pixel k is being computed:
    //   r_rdata = s[k+1], r_sh1 = s[k], r_sh2 = s[k-1]
    assign w_border = (r_col == c_COL_ZERO) || (r_col == c_LAST_COL);
`ifdef BLOB_FEEDER_ERODE_EN
    assign w_core   = r_sh2 & r_sh1 & r_rdata;
`else
    assign w_core   = r_sh1;
`endif
    assign w_rep_bit = w_core & ~w_border;

    // ------------------------------------------------------------------
    // Frame store: single clock, 1-cycle read latency, contents not reset
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wbit;
        end
        r_rdata <= r_mem[r_raddr];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sh1 <= 1'b0;
`ifdef BLOB_FEEDER_ERODE_EN
            r_sh2 <= 1'b0;
`endif
        end else begin
            r_sh1 <= r_rdata;
`ifdef BLOB_FEEDER_ERODE_EN
            r_sh2 <= r_sh1;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= c_S_WAIT;
            r_waddr    <= c_ADDR_ZERO;
            r_raddr    <= c_ADDR_ZERO;
            r_thr      <= 8'd0;
            r_col      <= c_COL_ZERO;
            r_row      <= c_ROW_ZERO;
            r_pf_cnt   <= 1'b0;
            r_last     <= 1'b0;
            r_valid    <= 1'b0;
            r_seq      <= 1'b0;
            r_drop_cnt <= 8'd0;
        end else begin
            r_valid <= 1'b0;

            if (w_drop && (r_drop_cnt != c_DROP_MAX)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end

            // Saturate so the look-ahead read never leaves the store.
            if (w_rd_adv && (r_raddr != c_LAST_ADDR)) begin
                r_raddr <= r_raddr + c_ADDR_ONE;
            end

            case (r_state)
                c_S_WAIT: begin
                    if (i_frame_start) begin
                        r_thr   <= i_threshold;
                        r_waddr <= c_ADDR_ONE;
                        r_state <= c_S_CAPTURE;
                    end
                end

                c_S_CAPTURE: begin
                    if (i_pix_valid && (r_waddr == c_LAST_ADDR)) begin
                        r_state  <= c_S_PREFETCH;
                        r_waddr  <= c_ADDR_ZERO;
                        r_raddr  <= c_ADDR_ZERO;
                        r_pf_cnt <= 1'b0;
                        r_col    <= c_COL_ZERO;
                        r_row    <= c_ROW_ZERO;
                        r_last   <= 1'b0;
                    end else if (i_frame_start) begin
                        // Restart: this pixel already went to address 0.
                        r_thr   <= i_threshold;
                        r_waddr <= c_ADDR_ONE;
                    end else if (i_pix_valid) begin
                        r_waddr <= r_waddr + c_ADDR_ONE;
                    end
                end

                c_S_PREFETCH: begin
                    r_pf_cnt <= 1'b1;
                    if (r_pf_cnt) begin
                        r_valid <= 1'b1;
                        r_state <= c_S_ARM;
                    end
                end

                c_S_ARM: begin
                    r_state <= c_S_REPLAY;
                end

                c_S_REPLAY: begin
                    if (r_last) begin
                        r_seq   <= 1'b0;
                        r_state <= c_S_HOLD;
                    end
                end

                c_S_HOLD: begin
                    r_seq <= 1'b0;
                    if (i_blob_done) begin
                        r_state <= c_S_WAIT;
                    end
                end

                default: begin
                    r_state <= c_S_WAIT;
                end
            endcase

            if (w_emit) begin
                r_seq  <= w_rep_bit;
                r_last <= (r_col == c_LAST_COL) && (r_row == c_LAST_ROW);
                if (r_col == c_LAST_COL) begin
                    r_col <= c_COL_ZERO;
                    r_row <= r_row + c_ROW_ONE;
                end else begin
                    r_col <= r_col + c_COL_ONE;
                end
            end
        end
    end

    assign o_valid    = r_valid;
    assign o_seq      = r_seq;
    assign o_busy     = (r_state != c_S_WAIT);
    assign o_drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire
